// File: rtl/mem_8_arb_pkg.sv
// Shared types and defaults for the xillybus mem_8 RAM arbiter.
package mem_8_arb_pkg;

  typedef enum logic {
    HOST_OPEN = 1'b0,
    INT_OWN   = 1'b1
  } owner_e;

  localparam int DEF_MAX_BURST    = 8;
  localparam int DEF_HOST_QUANTUM = 4;

endpackage

// File: rtl/byte_ram_1p.sv
// Single-port synchronous RAM, read-before-write, contents not reset.
module byte_ram_1p #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              bus_clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge bus_clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mem_8_arbiter.sv
// Shares the mem_8 demo RAM between the xillybus host port and a burst-capped
// internal requester; the host is stalled through empty/full while the requester owns it.
module mem_8_arbiter
  import mem_8_arb_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int HOST_QUANTUM = DEF_HOST_QUANTUM
) (
  input  logic              bus_clk,
  input  logic              srst,
  input  logic              host_rden,
  output logic              host_empty,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_wren,
  output logic              host_full,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              int_req,
  input  logic              int_we,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [DATA_W-1:0] int_wdata,
  input  logic              int_last,
  output logic              int_gnt,
  output logic              int_rvalid,
  output logic [DATA_W-1:0] int_rdata
);

  localparam int HC_W = $clog2(HOST_QUANTUM + 1);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [HC_W-1:0] HQ = HC_W'(HOST_QUANTUM);
  localparam logic [BC_W-1:0] MB = BC_W'(MAX_BURST);

  owner_e            state, state_nxt;
  logic [HC_W-1:0]   host_cnt, host_cnt_nxt;
  logic [BC_W-1:0]   burst_cnt, burst_cnt_nxt, burst_inc;
  logic              host_acc;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              rd_host_p0, rd_host_p1;
  logic              vld_p0, vld_p1;
  logic [DATA_W-1:0] host_hold_p1, int_hold_p1;

  assign host_acc  = host_rden | host_wren;
  assign burst_inc = burst_cnt + BC_W'(1);

  // Stage p0: ownership decision and RAM port mux
  always_comb begin
    state_nxt     = state;
    host_cnt_nxt  = host_cnt;
    burst_cnt_nxt = burst_cnt;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = host_addr;
    ram_wdata     = host_wdata;
    rd_host_p0    = 1'b0;
    vld_p0        = 1'b0;
    unique case (state)
      HOST_OPEN: begin
        ram_en     = host_acc;
        ram_we     = host_wren;
        rd_host_p0 = host_rden;
        if (host_acc && (host_cnt != HQ)) host_cnt_nxt = host_cnt + HC_W'(1);
        // The host access of the deciding cycle still completes.
        if (int_req && (!host_acc || (host_cnt == HQ))) begin
          state_nxt     = INT_OWN;
          burst_cnt_nxt = '0;
        end
      end
      INT_OWN: begin
        ram_addr  = int_addr;
        ram_wdata = int_wdata;
        if (int_req) begin
          ram_en        = 1'b1;
          ram_we        = int_we;
          vld_p0        = !int_we;
          burst_cnt_nxt = burst_inc;
          if (int_last || (burst_inc == MB)) begin
            state_nxt    = HOST_OPEN;
            host_cnt_nxt = '0;
          end
        end else begin
          state_nxt    = HOST_OPEN;
          host_cnt_nxt = '0;
        end
      end
      default: state_nxt = HOST_OPEN;
    endcase
    if (srst) ram_en = 1'b0;
  end

  byte_ram_1p #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .bus_clk (bus_clk),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_q)
  );

  // Stage p1: owner/read tag follows the RAM's 1-cycle read latency
  always_ff @(posedge bus_clk) begin
    if (srst) begin
      state        <= HOST_OPEN;
      host_cnt     <= '0;
      burst_cnt    <= '0;
      rd_host_p1   <= 1'b0;
      vld_p1       <= 1'b0;
      host_hold_p1 <= '0;
      int_hold_p1  <= '0;
    end else begin
      state        <= state_nxt;
      host_cnt     <= host_cnt_nxt;
      burst_cnt    <= burst_cnt_nxt;
      rd_host_p1   <= rd_host_p0;
      vld_p1       <= vld_p0;
      host_hold_p1 <= host_rdata;
      int_hold_p1  <= int_rdata;
    end
  end

  assign int_gnt    = (state == INT_OWN);
  assign host_empty = (state == INT_OWN);
  assign host_full  = (state == INT_OWN);
  assign int_rvalid = vld_p1;
  assign host_rdata = rd_host_p1 ? ram_q : host_hold_p1;
  assign int_rdata  = vld_p1 ? ram_q : int_hold_p1;

endmodule
